// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS main controller.
// master = controller side, slave = datapath/IR side.
interface mips_multicycle_control_if #(
  parameter int unsigned COUNT_W = 32
);
  logic [5:0]         Opcode;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               IRWrite;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               IllegalOp;
  logic [COUNT_W-1:0] InstrCount;
  logic [3:0]         State;

  modport master (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp,
           InstrCount, State
  );

  modport slave (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp,
           InstrCount, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath with memory-ready stalls.
// Optional macro MIPS_ADDI_EN adds the ADDI_EX/ADDI_WB path for opcode 8.
module mips_multicycle_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_multicycle_control_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
`ifdef MIPS_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'd8;
`endif
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
`ifdef MIPS_ADDI_EN
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
`endif
    S_INIT    = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] count_q;
  logic               illegal_c;
  logic               retire_c;
  logic               fetch_done_c;

  // Moore output decode for a given state; registered against the next state.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXECUTE: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:  begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
`ifdef MIPS_ADDI_EN
      S_ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDI_WB: c.reg_write = 1'b1;
`endif
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Next-state, illegal-opcode flag and retirement strobe.
  always_comb begin
    state_d   = state_q;
    illegal_c = 1'b0;
    retire_c  = 1'b0;
    case (state_q)
      S_INIT:    state_d = S_FETCH;
      S_FETCH:   if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWB:   begin state_d = S_FETCH; retire_c = 1'b1; end
      S_MEMWR: begin
        if (bus.MemReady) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   begin state_d = S_FETCH; retire_c = 1'b1; end
      S_BRANCH:  begin state_d = S_FETCH; retire_c = 1'b1; end
      S_JUMP:    begin state_d = S_FETCH; retire_c = 1'b1; end
`ifdef MIPS_ADDI_EN
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: begin state_d = S_FETCH; retire_c = 1'b1; end
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  assign ctrl_d = decode(state_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      ctrl_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (retire_c) count_q <= count_q + COUNT_W'(1);
    end
  end

  // IR/PC load in FETCH completes in the same cycle memory reports ready.
  assign fetch_done_c = (state_q == S_FETCH) && bus.MemReady;

  assign bus.PCWrite     = ctrl_q.pc_write | fetch_done_c;
  assign bus.IRWrite     = fetch_done_c;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.IllegalOp   = illegal_c;
  assign bus.InstrCount  = count_q;
  assign bus.State       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control (COUNT_W=4 to exercise wrap).
module tb_mips_multicycle_control;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   exp_cnt = 0;

  mips_multicycle_control_if #(.COUNT_W(CW)) bus ();

  mips_multicycle_control #(.COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.IllegalOp};
  endfunction

  // Advance one clock, then apply this cycle's inputs and let outputs settle.
  task automatic cyc(input logic [5:0] op, input logic rdy);
    @(posedge clk);
    #1;
    bus.Opcode   = op;
    bus.MemReady = rdy;
    #1;
  endtask

  task automatic st(input string tag, input int s);
    chk(tag, 32'(bus.State), 32'(s));
  endtask

  task automatic cnt(input string tag);
    chk(tag, 32'(bus.InstrCount), 32'(exp_cnt % 16));
  endtask

  task automatic do_jump(input string tag);
    cyc(6'd2, 1'b1); st({tag, "_dec"}, 1);
    cyc(6'd2, 1'b1); st({tag, "_jmp"}, 9);
    chk({tag, "_pcw"}, 32'(bus.PCWrite), 32'd1);
    chk({tag, "_pcsrc"}, 32'(bus.PCSource), 32'd2);
    exp_cnt++;
    cyc(6'd2, 1'b1); st({tag, "_fetch"}, 0); cnt({tag, "_cnt"});
  endtask

  initial begin
    reset        = 1'b1;
    bus.Opcode   = 6'd0;
    bus.MemReady = 1'b1;
    #12;
    st("rst_state", 15);
    chk("rst_outs", 32'(all_outs()), 32'd0);
    cnt("rst_cnt");
    reset = 1'b0;

    // First fetch after reset release
    cyc(6'd0, 1'b1); st("f0_state", 0);
    chk("f0_memrd", 32'(bus.MemRead), 32'd1);
    chk("f0_alusrcb", 32'(bus.ALUSrcB), 32'd1);
    chk("f0_irw", 32'(bus.IRWrite), 32'd1);

    // R-type: 0,1,6,7,0
    cyc(6'd0, 1'b1); st("r_dec", 1);
    chk("r_dec_srcb", 32'(bus.ALUSrcB), 32'd3);
    cyc(6'd0, 1'b1); st("r_exe", 6);
    chk("r_exe_aluop", 32'(bus.ALUOp), 32'd2);
    chk("r_exe_srca", 32'(bus.ALUSrcA), 32'd1);
    cyc(6'd0, 1'b1); st("r_wb", 7);
    chk("r_wb_regw", 32'(bus.RegWrite), 32'd1);
    chk("r_wb_regdst", 32'(bus.RegDst), 32'd1);
    exp_cnt++;

    // Fetch stalled two cycles
    cyc(6'd0, 1'b0); st("fs_state0", 0); cnt("r_cnt");
    chk("fs_irw0", 32'(bus.IRWrite), 32'd0);
    chk("fs_pcw0", 32'(bus.PCWrite), 32'd0);
    cyc(6'd0, 1'b0); st("fs_state1", 0);
    chk("fs_irw1", 32'(bus.IRWrite), 32'd0);
    cyc(6'd35, 1'b1); st("fs_state2", 0);
    chk("fs_irw2", 32'(bus.IRWrite), 32'd1);
    chk("fs_pcw2", 32'(bus.PCWrite), 32'd1);

    // lw with 3 wait cycles in MEMRD
    cyc(6'd35, 1'b1); st("lw_dec", 1);
    cyc(6'd35, 1'b1); st("lw_adr", 2);
    chk("lw_adr_srcb", 32'(bus.ALUSrcB), 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(6'd35, (i == 3) ? 1'b1 : 1'b0);
      st("lw_rd", 3);
      chk("lw_rd_memrd", 32'(bus.MemRead), 32'd1);
      chk("lw_rd_iord", 32'(bus.IorD), 32'd1);
    end
    cyc(6'd35, 1'b1); st("lw_wb", 4);
    chk("lw_wb_m2r", 32'(bus.MemtoReg), 32'd1);
    chk("lw_wb_regw", 32'(bus.RegWrite), 32'd1);
    cnt("lw_wb_cnt");
    exp_cnt++;
    cyc(6'd43, 1'b1); st("lw_fetch", 0); cnt("lw_cnt");

    // sw with one wait cycle
    cyc(6'd43, 1'b1); st("sw_dec", 1);
    cyc(6'd43, 1'b1); st("sw_adr", 2);
    cyc(6'd43, 1'b0); st("sw_wr0", 5);
    chk("sw_memw", 32'(bus.MemWrite), 32'd1);
    chk("sw_iord", 32'(bus.IorD), 32'd1);
    cyc(6'd43, 1'b1); st("sw_wr1", 5);
    cnt("sw_wait_cnt");
    exp_cnt++;
    cyc(6'd4, 1'b1); st("sw_fetch", 0); cnt("sw_cnt");

    // beq
    cyc(6'd4, 1'b1); st("beq_dec", 1);
    cyc(6'd4, 1'b1); st("beq_br", 8);
    chk("beq_aluop", 32'(bus.ALUOp), 32'd1);
    chk("beq_pcwc", 32'(bus.PCWriteCond), 32'd1);
    chk("beq_pcsrc", 32'(bus.PCSource), 32'd1);
    exp_cnt++;
    cyc(6'd2, 1'b1); st("beq_fetch", 0); cnt("beq_cnt");

    do_jump("j");

    // Opcode 8
    cyc(6'd8, 1'b1); st("op8_dec", 1);
`ifdef MIPS_ADDI_EN
    chk("op8_ill", 32'(bus.IllegalOp), 32'd0);
    cyc(6'd8, 1'b1); st("addi_ex", 10);
    chk("addi_ex_srcb", 32'(bus.ALUSrcB), 32'd2);
    cyc(6'd8, 1'b1); st("addi_wb", 11);
    chk("addi_wb_regw", 32'(bus.RegWrite), 32'd1);
    chk("addi_wb_regdst", 32'(bus.RegDst), 32'd0);
    exp_cnt++;
`else
    chk("op8_ill", 32'(bus.IllegalOp), 32'd1);
`endif
    cyc(6'd63, 1'b1); st("op8_fetch", 0); cnt("op8_cnt");
    chk("op8_ill_clr", 32'(bus.IllegalOp), 32'd0);

    // Unsupported opcode 63
    cyc(6'd63, 1'b1); st("op63_dec", 1);
    chk("op63_ill", 32'(bus.IllegalOp), 32'd1);
    cyc(6'd2, 1'b1); st("op63_fetch", 0); cnt("op63_cnt");

    // Retire enough jumps to wrap the 4-bit counter
    for (int i = 0; i < 16; i++) do_jump("wrap");

    // Reset asserted mid-MEMRD
    cyc(6'd35, 1'b1); st("rr_dec", 1);
    cyc(6'd35, 1'b1); st("rr_adr", 2);
    cyc(6'd35, 1'b0); st("rr_rd", 3);
    chk("rr_memrd", 32'(bus.MemRead), 32'd1);
    reset = 1'b1;
    #1;
    st("rr_state", 15);
    chk("rr_outs", 32'(all_outs()), 32'd0);
    exp_cnt = 0;
    cnt("rr_cnt");
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    st("rr_init", 15);
    chk("rr_init_outs", 32'(all_outs()), 32'd0);
    cyc(6'd0, 1'b1); st("rr_fetch", 0);
    chk("rr_fetch_memrd", 32'(bus.MemRead), 32'd1);
    chk("rr_fetch_srcb", 32'(bus.ALUSrcB), 32'd1);
    cnt("rr_fetch_cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALUOp code consumed by the ALU control unit, plus all datapath mux selects and write enables.
- Sits between the instruction register (opcode source) and the datapath. Stalls on a memory ready handshake.

Parameters:
COUNT_W, 32, width of retired-instruction counter InstrCount

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Opcode  input  6  IR[31:26]; stable from DECODE until next FETCH
MemReady  input  1  memory completes current read/write this cycle
PCWrite  output  1  unconditional PC write enable
PCWriteCond  output  1  PC write if ALU Zero (beq)
IorD  output  1  0=PC address, 1=ALUOut address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  1=MDR to register file
IRWrite  output  1  instruction register load
RegDst  output  1  1=rd, 0=rt
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
IllegalOp  output  1  unsupported opcode seen in DECODE
InstrCount  output  COUNT_W  retired instruction count, wraps
State  output  4  current state, debug

Behaviour:
- Reset and clocking:
  - Reset (async, active-high) forces State=INIT(15) and InstrCount=0.
  - Every output is 0 while State=INIT.
  - INIT->FETCH unconditionally on the next clk edge after reset deasserts.
- Output decoding:
  - Outputs are Moore-decoded from State. The exceptions are IRWrite/PCWrite in FETCH and IllegalOp, which also depend on inputs.
  - Any signal not listed for a state is 0.
- States (encoding, asserted outputs, next state):
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady. MemReady ? DECODE : FETCH.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by Opcode:
    - 35 (lw) or 43 (sw) -> MEMADR
    - 0 -> EXECUTE
    - 4 -> BRANCH
    - 2 -> JUMP
    - 8 -> see optional feature
    - other -> FETCH, with IllegalOp=1 for this cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): MemRead=1, IorD=1. MemReady ? MEMWB : MEMRD.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. MemReady ? FETCH : MEMWR.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP(9): PCWrite=1, PCSource=10 -> FETCH.
  - Unused encodings (10-14 when feature off): go to FETCH; all outputs 0.
- Memory handshake:
  - MemRead/MemWrite stay asserted and address selects stay constant for every wait cycle until MemReady=1.
  - MemReady is ignored outside FETCH/MEMRD/MEMWR.
- InstrCount:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDI_WB.
  - Does not increment on the illegal-opcode path or on INIT->FETCH.
  - Wraps from 2^COUNT_W-1 to 0.
- Latency with MemReady tied 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3 cycles.
  - Each MemReady=0 cycle adds one.
- Reset mid-instruction: any pending write enable drops immediately (asynchronously). The instruction is abandoned and not counted.

Optional Feature:
- Macro: MIPS_ADDI_EN.
- Defined: Opcode 8 in DECODE goes to ADDI_EX(10), then ADDI_WB(11), then FETCH (counted). Latency is 4 cycles.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1.
- Undefined: Opcode 8 is illegal. IllegalOp=1 in DECODE, then FETCH. States 10/11 do not exist.

Test Plan:
- Assert reset during MEMRD with MemRead=1 -> all outputs 0 in the same cycle, State=15, InstrCount=0. After release: one INIT cycle, then FETCH with MemRead=1, ALUSrcB=01.
- Opcode=0, MemReady=1 -> State sequence 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1, RegDst=1 in state 7. InstrCount 0->1.
- Opcode=35, MemReady low for 3 cycles in MEMRD -> MemRead=1, IorD=1 held 4 cycles. MEMWB asserts MemtoReg=1, RegWrite=1. 8 cycles FETCH-to-FETCH.
- FETCH with MemReady=0 for 2 cycles -> IRWrite=PCWrite=0 for those 2 cycles and =1 on cycle 3. DECODE follows.
- Opcode=4 -> BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01. Opcode=2 -> JUMP shows PCWrite=1, PCSource=10. Each takes 3 cycles and increments InstrCount.
- Opcode=8 -> without MIPS_ADDI_EN: IllegalOp=1 in DECODE, then FETCH, InstrCount unchanged. With MIPS_ADDI_EN: states 0,1,10,11,0, RegWrite=1 with RegDst=0 in state 11. Also preload InstrCount to all-ones (COUNT_W=4) and retire one instruction -> InstrCount=0.
